// File: rtl/brlwe_result_deserializer.sv
// Collects the BRLWE core's bit-serial result stream into a WIDTH-bit register and
// hands it to the host as a parallel word or as a show-ahead byte-pop stream.
module brlwe_result_deserializer #(
  parameter int WIDTH   = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             arm,
  input  logic             s_valid,
  input  logic             s_bit,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             rd_empty
);

  localparam int NBYTES = WIDTH / 8;
  localparam int BCW    = $clog2(WIDTH + 1);
  localparam int ICW    = $clog2(TIMEOUT + 1);
  localparam int PW     = $clog2(NBYTES + 1);

  localparam logic [BCW-1:0] LAST_BIT  = BCW'(WIDTH - 1);
  localparam logic [ICW-1:0] LAST_IDLE = ICW'(TIMEOUT - 1);
  localparam logic [PW-1:0]  END_PTR   = PW'(NBYTES);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic [BCW-1:0]   bit_cnt_q;
  logic [ICW-1:0]   idle_cnt_q;
  logic [PW-1:0]    rd_ptr_q;
  logic             done_q;
  logic             busy_q;
  logic             err_q;
  logic             capture;
  logic [7:0]       byte_lane [NBYTES];

  assign capture = (state_q == COLLECT) && s_valid && !arm;

  // Per-bit write enable decoded from bit_cnt; arm wipes the whole word.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign result_d[gi] = arm ? 1'b0 :
                            (capture && (bit_cnt_q == BCW'(gi))) ? s_bit : result_q[gi];
    end
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      assign byte_lane[gi] = result_q[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      result_q   <= '0;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      rd_ptr_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      result_q <= result_d;
      if (arm) begin
        state_q    <= COLLECT;
        bit_cnt_q  <= '0;
        idle_cnt_q <= '0;
        rd_ptr_q   <= '0;
        done_q     <= 1'b0;
        busy_q     <= 1'b1;
        err_q      <= 1'b0;
      end else begin
        if (rd_en && !rd_empty) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        case (state_q)
          COLLECT: begin
            if (s_valid) begin
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              idle_cnt_q <= '0;
              if (bit_cnt_q == LAST_BIT) begin
                state_q <= DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end else if (idle_cnt_q == LAST_IDLE) begin
              // Stalled stream: keep the partial word but never report it as done.
              state_q <= IDLE;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
          DONE: begin
            if (s_valid) begin
              err_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_empty = !done_q || (rd_ptr_q == END_PTR);

  always_comb begin
    rd_data = 8'h00;
    if (!rd_empty) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (rd_ptr_q == PW'(i)) begin
          rd_data = byte_lane[i];
        end
      end
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule

// File: tb/tb_brlwe_result_deserializer.sv
// Directed bench for brlwe_result_deserializer with WIDTH=256, TIMEOUT=8.
module tb_brlwe_result_deserializer;

  localparam int W = 256;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         arm = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_bit = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] result;
  logic         done, busy, err, rd_empty;
  logic [7:0]   rd_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Hand-derived frame images.
  localparam logic [W-1:0] PAT_XOR  = {16{16'h55AA}};            // bit i = i[0]^i[3]
  localparam logic [W-1:0] PAT_HEX  = {4{64'h0123456789ABCDEF}};
  localparam logic [W-1:0] PAT_C    = {64{4'hC}};                // bit i = i[1]
  localparam logic [W-1:0] PAT_ONES = {W{1'b1}};
  logic [7:0] hex_bytes [8] = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

  brlwe_result_deserializer #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .arm      (arm),
    .s_valid  (s_valid),
    .s_bit    (s_bit),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .err      (err),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_empty (rd_empty)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_arm(input logic v, input logic b);
    arm = 1'b1; s_valid = v; s_bit = b;
    tick();
    arm = 1'b0; s_valid = 1'b0; s_bit = 1'b0;
  endtask

  // Sends bits lo..hi of v, each beat followed by gap idle cycles.
  task automatic send_bits(input logic [W-1:0] v, input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      s_valid = 1'b1; s_bit = v[i];
      tick();
      s_valid = 1'b0; s_bit = 1'b0;
      repeat (gap) tick();
    end
  endtask

  initial begin
    #2;
    check("rst_result", result, '0);
    check("rst_done", W'(done), 0);
    check("rst_busy", W'(busy), 0);
    check("rst_err", W'(err), 0);
    check("rst_empty", W'(rd_empty), 1);
    check("rst_rd_data", W'(rd_data), 0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    // Beats while IDLE are ignored without error.
    send_bits(PAT_ONES, 0, 3, 0);
    check("idle_result", result, '0);
    check("idle_err", W'(err), 0);
    $display("step idle_beats done");

    // Basic frame.
    do_arm(1'b0, 1'b0);
    check("arm_busy", W'(busy), 1);
    send_bits(PAT_XOR, 0, 254, 0);
    check("basic_done_early", W'(done), 0);
    check("basic_busy_early", W'(busy), 1);
    send_bits(PAT_XOR, 255, 255, 0);
    check("basic_result", result, PAT_XOR);
    check("basic_done", W'(done), 1);
    check("basic_busy", W'(busy), 0);
    check("basic_err", W'(err), 0);
    check("basic_byte0", W'(rd_data), 8'hAA);
    $display("step basic_frame done");

    // Overrun.
    send_bits(PAT_ONES, 0, 0, 0);
    check("ovr_err", W'(err), 1);
    check("ovr_done", W'(done), 1);
    check("ovr_result", result, PAT_XOR);
    $display("step overrun done");

    // Arm with a simultaneous beat: beat dropped, error and frame cleared.
    do_arm(1'b1, 1'b1);
    check("arm_clr_result", result, '0);
    check("arm_clr_err", W'(err), 0);
    check("arm_clr_done", W'(done), 0);
    check("arm_clr_empty", W'(rd_empty), 1);
    send_bits(PAT_HEX, 0, 255, 0);
    check("hex_result", result, PAT_HEX);
    check("hex_done", W'(done), 1);
    $display("step arm_with_beat done");

    // Byte drain with sustained rd_en.
    rd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k < 32) begin
        check($sformatf("drain_data_%0d", k), W'(rd_data), W'(hex_bytes[k % 8]));
        check($sformatf("drain_empty_%0d", k), W'(rd_empty), 0);
      end else begin
        check($sformatf("drain_data_%0d", k), W'(rd_data), 0);
        check($sformatf("drain_empty_%0d", k), W'(rd_empty), 1);
      end
      tick();
    end
    rd_en = 1'b0;
    check("drain_result_kept", result, PAT_HEX);
    $display("step byte_drain done");

    // Gapped stream with 7-idle-cycle gaps, including before the first beat.
    do_arm(1'b0, 1'b0);
    repeat (7) tick();
    send_bits(PAT_C, 0, 255, 7);
    check("gap_result", result, PAT_C);
    check("gap_done", W'(done), 1);
    check("gap_err", W'(err), 0);
    check("gap_byte0", W'(rd_data), 8'hCC);
    $display("step gapped_frame done");

    // Timeout on an 8-cycle gap.
    do_arm(1'b0, 1'b0);
    send_bits(PAT_ONES, 0, 9, 0);
    repeat (7) tick();
    check("to_err_early", W'(err), 0);
    check("to_busy_early", W'(busy), 1);
    tick();
    check("to_err", W'(err), 1);
    check("to_busy", W'(busy), 0);
    check("to_done", W'(done), 0);
    check("to_empty", W'(rd_empty), 1);
    check("to_partial", result, W'(10'h3FF));
    send_bits(PAT_ONES, 0, 1, 0);
    check("to_late_beat", result, W'(10'h3FF));
    $display("step timeout done");

    // Re-arm after 100 bits, then a clean full frame.
    do_arm(1'b0, 1'b0);
    send_bits(PAT_ONES, 0, 99, 0);
    do_arm(1'b0, 1'b0);
    check("rearm_result", result, '0);
    send_bits(PAT_XOR, 0, 255, 0);
    check("rearm_frame", result, PAT_XOR);
    check("rearm_done", W'(done), 1);
    check("rearm_err", W'(err), 0);
    $display("step rearm done");

    // Asynchronous reset mid-frame.
    do_arm(1'b0, 1'b0);
    send_bits(PAT_ONES, 0, 49, 0);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_result", result, '0);
    check("arst_busy", W'(busy), 0);
    check("arst_done", W'(done), 0);
    check("arst_err", W'(err), 0);
    check("arst_empty", W'(rd_empty), 1);
    @(negedge clock);
    resetn = 1'b1;
    tick();
    send_bits(PAT_ONES, 0, 9, 0);
    check("arst_no_capture", result, '0);
    check("arst_no_busy", W'(busy), 0);
    $display("step async_reset done");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
